mac_result_writer: RTL and testbench
====================================

// Module: mac_result_writer
// PURPOSE
//  Streaming multiply-accumulate stage between the MEM_A/MEM_B read ports and the MEM_C write port of the
//  64x64 matrix-multiply engine. Takes one 8b A element and one 8b B element per valid cycle.
//  Accumulates K=64 products into one 22b dot product.
//  Writes each result into MEM_C (rflp4096x22mx4) at a sequential address, from 0 to NOUT-1.
// PARAMETERS
//  DW    8     operand width (unsigned)
//  ACCW  22    accumulator / MEM_C data width; 64*255*255 = 4161600 < 2^22, no overflow possible
//  K     64    products per dot product
//  NOUT  4096  results per run (MEM_C depth)
// PORTS
//  clk     in   1     system clock, all state on rising edge
//  rstn    in   1     asynchronous active-low reset
//  start   in   1     1-cycle pulse: begin a run (honoured in IDLE or DONE only)
//  in_valid in  1     in_a/in_b carry a valid operand pair this cycle
//  in_a    in   DW    element from MEM_A DO
//  in_b    in   DW    element from MEM_B DO
//  c_din   out  ACCW  MEM_C DIN
//  c_ra    out  10    MEM_C row address = out_idx[11:2]
//  c_ca    out  2     MEM_C column address = out_idx[1:0]
//  c_nwrt  out  1     MEM_C write enable, active low
//  c_nce   out  1     MEM_C chip enable, active low
//  busy    out  1     high in RUN and DRAIN
//  done    out  1     high in DONE; held until next start
// BEHAVIOUR
//  Reset values: c_din=0, c_ra=0, c_ca=0, c_nwrt=1, c_nce=1, busy=0, done=0.
//  Reset also clears the state (to IDLE), k_cnt, out_idx, prod, prod_v, prod_last and acc.
//  States:
//   IDLE->RUN on start. DONE->RUN on start.
//   RUN->DRAIN when the last pair of result NOUT-1 is accepted.
//   DRAIN->DONE after that result's write strobe.
//  Entering RUN clears k_cnt (6b), out_idx (12b) and acc.
//  The stage is a 2-stage pipeline with no backpressure. in_valid may have gaps of any length.
//  Stage 1: in RUN and in_valid, register prod=in_a*in_b (16b, unsigned), prod_v=1.
//   Also register prod_last=(k_cnt==K-1), then k_cnt++ (wraps at K).
//   in_valid is ignored in IDLE, DRAIN and DONE.
//  Stage 2: when prod_v, sum = (first ? 0 : acc) + zero-extended prod.
//   first = the previous stage-2 product was a last, or this is the first product of the run.
//   If prod_last is 0: acc <= sum.
//   If prod_last is 1: c_din <= sum; c_nce, c_nwrt <= 0 for exactly one cycle; c_ra/c_ca <= out_idx.
//   On that same edge out_idx++. The next product restarts accumulation from 0.
//  Latency: last pair presented in cycle t. Write strobe is low during cycle t+2. MEM_C samples at end of t+2.
//  Back-to-back dot products (no gap) therefore produce write strobes every K cycles. No strobes merge.
//  Outside a write cycle: c_nce=c_nwrt=1. c_din/c_ra/c_ca hold their last value.
//  start in RUN or DRAIN is ignored.
//  rstn low mid-run: strobes go inactive immediately (async), outputs go to reset values, and the run is abandoned.
//  out_idx wraps 4095->0 only via a new start. Exactly NOUT writes per run.
//  done rises in the cycle after the final strobe cycle. busy falls on the same edge.
// TESTING
//  1 start, 64 pairs a=1,b=1 back-to-back -> one strobe 2 cycles after the last pair, c_din=64, ra=0, ca=0.
//  2 64 pairs a=255,b=255 -> c_din=4161600 (0x3F8040). Then 64 pairs a=2,b=3 -> addr 1, c_din=384 (acc restarted).
//  3 same as test 1 but in_valid toggled 1-0-0-1... -> c_din=64, strobe only after the 64th valid pair, single cycle.
//  4 full run, pair j of result i: a=i[7:0], b=1 -> 4096 strobes.
//    Addresses 0..4095, with ca=i[1:0] and ra=i[11:2]. c_din=64*(i mod 256). done=1 after the last strobe, busy=0.
//  5 start pulsed mid-run and in_valid driven in DONE -> no effect on k_cnt, out_idx or strobes. done held.
//  6 rstn low after 30 pairs of result 5 -> all outputs at reset values.
//    Then start + 64 pairs of 1 -> write at addr 0, c_din=64.

Source files
------------

// File: rtl/mac_result_writer.sv
// Streaming 8b x 8b multiply-accumulate stage feeding the MEM_C write port.
// A two-stage pipeline (multiply, then accumulate/write) with no backpressure.
module mac_result_writer #(
    parameter int unsigned DW   = 8,
    parameter int unsigned ACCW = 22,
    parameter int unsigned K    = 64,
    parameter int unsigned NOUT = 4096
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic            in_valid,
    input  logic [DW-1:0]   in_a,
    input  logic [DW-1:0]   in_b,
    output logic [ACCW-1:0] c_din,
    output logic [9:0]      c_ra,
    output logic [1:0]      c_ca,
    output logic            c_nwrt,
    output logic            c_nce,
    output logic            busy,
    output logic            done
);

    localparam int unsigned KW = (K > 1) ? $clog2(K) : 1;
    localparam int unsigned PW = 2 * DW;
    localparam logic [KW-1:0] KLast   = KW'(K - 1);
    localparam logic [11:0]   OutLast = 12'(NOUT - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e          state_q, state_d;
    logic [KW-1:0]   k_cnt_q, k_cnt_d;
    logic [11:0]     out_idx_q, out_idx_d;
    logic [PW-1:0]   prod_q, prod_d;
    logic            prod_v_q, prod_v_d;
    logic            prod_last_q, prod_last_d;
    logic [ACCW-1:0] acc_q, acc_d;
    logic [ACCW-1:0] c_din_q, c_din_d;
    logic [11:0]     c_addr_q, c_addr_d;
    logic            wr_n_q, wr_n_d;

    logic            run_start;
    logic            accept;
    logic            k_last;
    logic [ACCW-1:0] sum;

    assign run_start = start && ((state_q == StIdle) || (state_q == StDone));
    assign accept    = (state_q == StRun) && in_valid;
    assign k_last    = (k_cnt_q == KLast);
    assign sum       = acc_q + ACCW'(prod_q);

    always_comb begin
        state_d     = state_q;
        k_cnt_d     = k_cnt_q;
        out_idx_d   = out_idx_q;
        prod_d      = prod_q;
        prod_v_d    = 1'b0;
        prod_last_d = prod_last_q;
        acc_d       = acc_q;
        c_din_d     = c_din_q;
        c_addr_d    = c_addr_q;
        wr_n_d      = 1'b1;

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                // out_idx already equals the index of the result whose last pair arrives here
                if (accept && k_last && (out_idx_q == OutLast)) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (!wr_n_q && (c_addr_q == OutLast)) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase

        // Stage 1: multiply
        if (accept) begin
            prod_d      = PW'(in_a) * PW'(in_b);
            prod_v_d    = 1'b1;
            prod_last_d = k_last;
            k_cnt_d     = k_last ? '0 : k_cnt_q + 1'b1;
        end

        // Stage 2: accumulate, or write out; clearing acc on a write restarts the next sum at 0
        if (prod_v_q) begin
            if (prod_last_q) begin
                c_din_d  = sum;
                c_addr_d = out_idx_q;
                wr_n_d   = 1'b0;
                acc_d    = '0;
                if (out_idx_q != OutLast) begin
                    out_idx_d = out_idx_q + 12'd1;
                end
            end else begin
                acc_d = sum;
            end
        end

        if (run_start) begin
            k_cnt_d   = '0;
            out_idx_d = '0;
            acc_d     = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            k_cnt_q     <= '0;
            out_idx_q   <= '0;
            prod_q      <= '0;
            prod_v_q    <= 1'b0;
            prod_last_q <= 1'b0;
            acc_q       <= '0;
            c_din_q     <= '0;
            c_addr_q    <= '0;
            wr_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            k_cnt_q     <= k_cnt_d;
            out_idx_q   <= out_idx_d;
            prod_q      <= prod_d;
            prod_v_q    <= prod_v_d;
            prod_last_q <= prod_last_d;
            acc_q       <= acc_d;
            c_din_q     <= c_din_d;
            c_addr_q    <= c_addr_d;
            wr_n_q      <= wr_n_d;
        end
    end

    assign c_din  = c_din_q;
    assign c_ra   = c_addr_q[11:2];
    assign c_ca   = c_addr_q[1:0];
    assign c_nwrt = wr_n_q;
    assign c_nce  = wr_n_q;
    assign busy   = (state_q == StRun) || (state_q == StDrain);
    assign done   = (state_q == StDone);

endmodule

// File: tb/tb_mac_result_writer.sv
// Directed bench for mac_result_writer: table of dot-product vectors plus
// hand-written sequences for run end, ignored start/in_valid and mid-run reset.
module tb_mac_result_writer;

    localparam int unsigned DW   = 8;
    localparam int unsigned ACCW = 22;
    localparam int unsigned K    = 64;
    localparam int unsigned NOUT = 32;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            start = 1'b0;
    logic            in_valid = 1'b0;
    logic [DW-1:0]   in_a = '0;
    logic [DW-1:0]   in_b = '0;
    logic [ACCW-1:0] c_din;
    logic [9:0]      c_ra;
    logic [1:0]      c_ca;
    logic            c_nwrt, c_nce, busy, done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    mac_result_writer #(
        .DW   (DW),
        .ACCW (ACCW),
        .K    (K),
        .NOUT (NOUT)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .start    (start),
        .in_valid (in_valid),
        .in_a     (in_a),
        .in_b     (in_b),
        .c_din    (c_din),
        .c_ra     (c_ra),
        .c_ca     (c_ca),
        .c_nwrt   (c_nwrt),
        .c_nce    (c_nce),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [ACCW-1:0] din;
        logic [11:0]     idx;
        int              cyc;
    } wr_t;

    typedef struct {
        logic [DW-1:0]   a;
        logic [DW-1:0]   b;
        int              gap;
        logic [ACCW-1:0] exp_din;
    } vec_t;

    wr_t  got_q[$];
    wr_t  exp_q[$];
    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Record every strobe cycle; a strobe longer than one cycle shows up as extra entries.
    always @(negedge clk) begin
        if (rstn && (!c_nce || !c_nwrt)) begin
            check("nwrt_eq_nce", {31'b0, c_nwrt}, {31'b0, c_nce});
            if (!c_nce) got_q.push_back('{din: c_din, idx: {c_ra, c_ca}, cyc: cyc});
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_a = 8'hAA;
            in_b = 8'h55;
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        in_valid = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic feed_pair(input logic [DW-1:0] a, input logic [DW-1:0] b, input int gap,
                             output int t);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        t = cyc;
        if (gap > 0) idle(gap);
    endtask

    task automatic feed_dot(input logic [DW-1:0] a, input logic [DW-1:0] b, input int gap,
                            input logic [ACCW-1:0] exp_din, input int idx, output int t_last);
        int t;
        t = 0;
        for (int j = 0; j < int'(K); j++) feed_pair(a, b, gap, t);
        t_last = t;
        exp_q.push_back('{din: exp_din, idx: idx[11:0], cyc: t + 2});
    endtask

    task automatic compare_writes(input string name);
        int n;
        check({name, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_din[%0d]", name, i), got_q[i].din, exp_q[i].din);
            check($sformatf("%s_addr[%0d]", name, i), got_q[i].idx, exp_q[i].idx);
            check($sformatf("%s_cycle[%0d]", name, i), got_q[i].cyc, exp_q[i].cyc);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_c_din"}, c_din, 0);
        check({name, "_c_ra"}, c_ra, 0);
        check({name, "_c_ca"}, c_ca, 0);
        check({name, "_c_nwrt"}, c_nwrt, 1);
        check({name, "_c_nce"}, c_nce, 1);
        check({name, "_busy"}, busy, 0);
        check({name, "_done"}, done, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, run did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        t = 0;
        vecs[0] = '{a: 8'd1,   b: 8'd1,   gap: 0, exp_din: 22'd64};
        vecs[1] = '{a: 8'd255, b: 8'd255, gap: 0, exp_din: 22'd4161600};
        vecs[2] = '{a: 8'd2,   b: 8'd3,   gap: 0, exp_din: 22'd384};
        vecs[3] = '{a: 8'd1,   b: 8'd1,   gap: 2, exp_din: 22'd64};
        vecs[4] = '{a: 8'd200, b: 8'd7,   gap: 1, exp_din: 22'd89600};

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rstn = 1'b1;

        // Run 1: table vectors, ignored mid-run start, then the rest of the run
        pulse_start();
        check("run1_busy", busy, 1);
        for (int v = 0; v < 5; v++) feed_dot(vecs[v].a, vecs[v].b, vecs[v].gap, vecs[v].exp_din, v, t);
        idle(4);
        pulse_start();
        check("midrun_busy", busy, 1);
        check("midrun_done", done, 0);
        for (int i = 5; i < int'(NOUT); i++) feed_dot(DW'(i), 8'd1, 0, ACCW'(64 * i), i, t);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("final_strobe_nce", c_nce, 0);
        check("final_strobe_busy", busy, 1);
        check("final_strobe_done", done, 0);
        @(negedge clk);
        check("after_final_nce", c_nce, 1);
        check("after_final_done", done, 1);
        check("after_final_busy", busy, 0);

        // in_valid in DONE must not produce strobes
        for (int i = 0; i < 10; i++) feed_pair(8'd7, 8'd7, 0, t);
        idle(4);
        check("done_held", done, 1);
        check("done_busy", busy, 0);
        check("hold_c_din", c_din, 64 * (NOUT - 1));
        check("hold_addr", {c_ra, c_ca}, NOUT - 1);
        compare_writes("run1");

        // Run 2: restart from DONE, then reset part-way through result 5
        pulse_start();
        check("run2_done", done, 0);
        check("run2_busy", busy, 1);
        for (int v = 0; v < 5; v++) feed_dot(vecs[v].a, vecs[v].b, vecs[v].gap, vecs[v].exp_din, v, t);
        for (int j = 0; j < 30; j++) feed_pair(8'd5, 8'd1, 0, t);
        @(posedge clk); #2;
        rstn = 1'b0;
        #1;
        check_reset_outputs("midrun_reset");
        compare_writes("run2");

        // Run 3: in_valid ignored in IDLE, then a fresh dot product at address 0
        idle(2);
        rstn = 1'b1;
        for (int i = 0; i < 10; i++) feed_pair(8'd9, 8'd9, 0, t);
        idle(2);
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_nce", c_nce, 1);
        pulse_start();
        feed_dot(8'd1, 8'd1, 0, 22'd64, 0, t);
        idle(4);
        compare_writes("run3");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
